// File: rtl/pc_fetch_unit.sv
// Program counter and next-PC selector for the word-addressed fetch stage.
// Chooses between sequential, branch, jump, jump-register and exception
// targets. A redirect that arrives while stalled is parked until the stall
// clears, and every non-sequential load of the PC raises a one-cycle flush.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [31:0] pc_plus1,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        exception,
  output logic [31:0] pc,
  output logic        fetch_valid,
  output logic        flush,
  output logic        pending
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        flush_q, flush_d;

  logic [31:0] sel_target;
  logic        redirect_req;

  // Target selection by priority; exception is handled separately because it
  // also overrides stall and the queued target.
  always_comb begin
    redirect_req = jr | jump | branch_taken;
    if (jr) begin
      sel_target = jr_target;
    end else if (jump) begin
      sel_target = {pc_plus1[31:26], jump_index};
    end else if (branch_taken) begin
      sel_target = pc_plus1 + {{16{branch_offset[15]}}, branch_offset};
    end else begin
      sel_target = pc_plus1;
    end
  end

  // Next-state, next-PC, queued target and flush decision.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    pend_target_d = pend_target_q;
    flush_d       = 1'b0;

    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end

      RUN: begin
        if (exception) begin
          pc_d    = EXC_VECTOR;
          flush_d = 1'b1;
        end else if (!stall) begin
          pc_d    = sel_target;
          flush_d = redirect_req;
        end else if (redirect_req) begin
          pend_target_d = sel_target;
          state_d       = HOLD;
        end
      end

      HOLD: begin
        if (exception) begin
          pc_d    = EXC_VECTOR;
          flush_d = 1'b1;
          state_d = RUN;
        end else if (!stall) begin
          pc_d    = pend_target_q;
          flush_d = 1'b1;
          state_d = RUN;
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // State, PC, queued target and flush registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR;
      pend_target_q <= 32'h0000_0000;
      flush_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_target_q <= pend_target_d;
      flush_q       <= flush_d;
    end
  end

  assign pc          = pc_q;
  assign flush       = flush_q;
  assign fetch_valid = (state_q != BOOT);
  assign pending     = (state_q == HOLD);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios followed by
// randomized traffic, all compared against a rule-level reference model.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_VEC = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC = 32'h0000_0020;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] pc_plus1;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_offset = '0;
  logic        jump = 1'b0;
  logic [25:0] jump_index = '0;
  logic        jr = 1'b0;
  logic [31:0] jr_target = '0;
  logic        exception = 1'b0;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        flush;
  logic        pending;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: PC, whether the boot cycle has passed, a queue holding
  // at most one parked redirect, and the flush expected after the last edge.
  logic [31:0] m_pc;
  bit          m_booted;
  logic [31:0] m_queue[$];
  bit          m_flush;

  always #5 clk = ~clk;

  // External incrementer.
  assign pc_plus1 = pc + 32'd1;

  pc_fetch_unit #(
    .RESET_VECTOR(RST_VEC),
    .EXC_VECTOR  (EXC_VEC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .pc_plus1     (pc_plus1),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .jump         (jump),
    .jump_index   (jump_index),
    .jr           (jr),
    .jr_target    (jr_target),
    .exception    (exception),
    .pc           (pc),
    .fetch_valid  (fetch_valid),
    .flush        (flush),
    .pending      (pending)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"}, pc, m_pc);
    check({tag, ".fetch_valid"}, {31'd0, fetch_valid}, {31'd0, m_booted});
    check({tag, ".flush"}, {31'd0, flush}, {31'd0, m_flush});
    check({tag, ".pending"}, {31'd0, pending}, {31'd0, (m_queue.size() != 0)});
  endtask

  task automatic model_reset();
    m_pc     = RST_VEC;
    m_booted = 0;
    m_queue.delete();
    m_flush  = 0;
  endtask

  // Advance the model by one clock edge from the current inputs.
  task automatic model_step();
    logic [31:0] seq;
    logic [31:0] tgt;
    bit          redir;
    seq     = m_pc + 32'd1;
    m_flush = 0;
    if (!m_booted) begin
      m_booted = 1;
    end else if (exception) begin
      m_pc = EXC_VEC;
      m_queue.delete();
      m_flush = 1;
    end else if (m_queue.size() != 0) begin
      if (!stall) begin
        m_pc    = m_queue.pop_front();
        m_flush = 1;
      end
    end else begin
      redir = 1;
      if (jr)                tgt = jr_target;
      else if (jump)         tgt = {seq[31:26], jump_index};
      else if (branch_taken) tgt = seq + 32'($signed(branch_offset));
      else begin
        tgt   = seq;
        redir = 0;
      end
      if (!stall) begin
        m_pc    = tgt;
        m_flush = redir;
      end else if (redir) begin
        m_queue.push_back(tgt);
      end
    end
  endtask

  // Apply inputs, clock once, then compare just after the edge.
  task automatic step(input string tag, input bit st, input bit br, input logic [15:0] off,
                      input bit jmp, input logic [25:0] idx, input bit jrr,
                      input logic [31:0] jt, input bit exc);
    stall = st; branch_taken = br; branch_offset = off;
    jump = jmp; jump_index = idx; jr = jrr; jr_target = jt; exception = exc;
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0);
  endtask

  task automatic go_to(input string tag, input logic [31:0] target);
    step(tag, 0, 0, 16'h0, 0, 26'h0, 1, target, 0);
  endtask

  // Asynchronous reset: outputs must change without waiting for an edge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    stall = 0; branch_taken = 0; jump = 0; jr = 0; exception = 0;
    model_reset();
    #2;
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #3;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Boot cycle ignores inputs, then free-run.
    step("boot_ignores", 0, 0, 16'h0, 0, 26'h0, 1, 32'h1234, 1);
    idle("seq1");
    idle("seq2");
    idle("seq3");

    // Backward branch from 0x10.
    go_to("to_10", 32'h10);
    step("branch_back", 0, 1, 16'hFFFC, 0, 26'h0, 0, 32'h0, 0);
    idle("after_branch");

    // Jump, then jr beating jump, then jump beating branch.
    go_to("to_jump_base", 32'h0400_0005);
    step("jump", 0, 0, 16'h0, 1, 26'h123, 0, 32'h0, 0);
    go_to("to_jump_base2", 32'h0400_0005);
    step("jr_wins", 0, 0, 16'h0, 1, 26'h123, 1, 32'h80, 0);
    step("jump_over_branch", 0, 1, 16'h0100, 1, 26'h77, 0, 32'h0, 0);
    idle("flush_once");

    // Stall with no request holds in place.
    step("stall_plain", 1, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0);

    // Redirect queued behind a stall; later requests ignored.
    go_to("to_20", 32'h20);
    step("queue_jump", 1, 0, 16'h0, 1, 26'h50, 0, 32'h0, 0);
    step("hold_ignore", 1, 0, 16'h0, 0, 26'h0, 1, 32'h999, 0);
    step("hold3", 1, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0);
    step("release", 0, 0, 16'h0, 0, 26'h0, 1, 32'h777, 0);
    idle("after_release");

    // Exception while holding with stall high.
    step("queue2", 1, 1, 16'h0008, 0, 26'h0, 0, 32'h0, 0);
    step("exc_in_hold", 1, 0, 16'h0, 0, 26'h0, 0, 32'h0, 1);
    idle("after_exc");

    // Wrap-around.
    go_to("to_max", 32'hFFFF_FFFF);
    idle("wrap");

    // Reset mid-HOLD.
    step("queue3", 1, 0, 16'h0, 1, 26'h3ff, 0, 32'h0, 0);
    do_reset("reset_mid_hold");
    idle("boot2");
    idle("run_after_reset");

    // Randomized traffic with occasional mid-run resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        do_reset("rand_reset");
      end else begin
        step("rand",
             $urandom_range(0, 99) < 30,
             $urandom_range(0, 99) < 20, 16'($urandom),
             $urandom_range(0, 99) < 10, 26'($urandom),
             $urandom_range(0, 99) < 8, $urandom,
             $urandom_range(0, 99) < 4);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter register and next-PC selector for the fetch stage of the word-addressed MIPS soft core.
- Drives the current PC to the incrementer and to instruction memory.
- Takes the incrementer result back and picks the next PC from one of: sequential, branch, jump, jump-register or exception vector.
- Holds the PC on stall, queues a redirect that arrives during a stall, and raises a one-cycle flush toward IF/ID after every applied redirect.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded at reset (word address).
- EXC_VECTOR, 32'h0000_0020, PC value loaded on exception (word address).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hazard stall; holds the PC.
- pc_plus1  input  32  incrementer result (pc + 1).
- branch_taken  input  1  conditional branch resolved taken.
- branch_offset  input  16  signed word offset.
- jump  input  1  J/JAL request.
- jump_index  input  26  instruction index field.
- jr  input  1  JR/JALR request.
- jr_target  input  32  register-sourced target (word address).
- exception  input  1  exception request.
- pc  output  32  current PC; goes to the incrementer and to imem address.
- fetch_valid  output  1  pc is a valid fetch address this cycle.
- flush  output  1  squash the instruction currently in IF/ID.
- pending  output  1  a redirect is queued behind a stall.

Behaviour:
- Reset (rst_n=0, async):
  - pc=RESET_VECTOR, fetch_valid=0, flush=0, pending=0, pend_target=0, state=BOOT.
- States: BOOT, RUN, HOLD.
  - BOOT: first clock edge after reset release goes to RUN. pc is unchanged on that edge and fetch_valid=1 from then on. All inputs are ignored in BOOT.
  - RUN:
    - stall=0: pc <= sel_target, where sel_target is the highest-priority request. Priority: exception > jr > jump > branch_taken > sequential.
    - stall=1 with no request: pc holds, state stays RUN.
    - stall=1 with any non-exception request: pend_target <= sel_target, pending=1, state goes to HOLD, pc holds.
  - HOLD:
    - stall=1: pc holds. New non-exception requests are ignored; the first queued target wins.
    - stall=0: pc <= pend_target, pending=0, state goes to RUN. Inputs in that cycle are ignored, except exception.
- Exception overrides stall in any non-BOOT state: pc <= EXC_VECTOR, pending cleared, state goes to RUN.
- Target arithmetic (all modulo 2^32, no overflow flag):
  - sequential = pc_plus1.
  - branch = pc_plus1 + sign_extend32(branch_offset).
  - jump = {pc_plus1[31:26], jump_index}.
  - jr = jr_target.
- flush:
  - Registered; equals 1 for exactly the cycle after any edge on which pc was loaded from a non-sequential source (branch, jump, jr, exception, pend_target).
  - Never asserted out of BOOT.
- Latency: a request presented with stall=0 appears on pc one cycle later.
- fetch_valid stays 1 in RUN and HOLD, including while stalled. Downstream gates on stall.
- Reset mid-operation: everything returns to the reset values immediately; a queued target is discarded.
- Simultaneous branch_taken and jump: jump wins; flush is asserted once.
- pc_plus1 is combinational from pc. The block must not form a loop other than through the pc register.

Test Plan:
- Reset then free-run, RESET_VECTOR=0:
  - Cycle 1 after release: pc=0, fetch_valid=1.
  - Then pc=1,2,3 on successive edges; flush=0 throughout.
- At pc=0x10: branch_taken=1, offset=16'hFFFC -> pc=0x0D next cycle; flush=1 for one cycle, then 0.
- At pc=0x0400_0005: jump=1, index=26'h123 -> pc=0x0400_0123. Same cycle with jr=1, jr_target=0x80 -> pc=0x80 (jr wins).
- Stall with queued redirect:
  - At pc=0x20 assert stall=1 and jump index 0x50 in the same cycle, keep stall high 3 cycles: pc stays 0x20, pending=1.
  - Release stall: pc=0x50, pending=0, flush=1.
- Exception during HOLD with stall=1 -> pc=0x20 (EXC_VECTOR) next edge, pending=0, flush=1.
- Wrap-around: at pc=0xFFFF_FFFF free-run -> pc=0x0000_0000. Assert rst_n=0 mid-HOLD -> pc=RESET_VECTOR and pending=0 immediately, without waiting for a clock edge.
